// File: rtl/alu_exec_unit_if.sv
// rtl/alu_exec_unit_if.sv - request/result bundle between the EX stage and the execute unit
interface alu_exec_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic [2:0]       ctrl_i;
  logic [WIDTH-1:0] data1_i;
  logic [WIDTH-1:0] data2_i;
  logic             abort_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] data_o;
  logic             zero_o;

  modport master (
    output start_i, ctrl_i, data1_i, data2_i, abort_i,
    input  busy_o, done_o, data_o, zero_o
  );

  modport slave (
    input  start_i, ctrl_i, data1_i, data2_i, abort_i,
    output busy_o, done_o, data_o, zero_o
  );
endinterface

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - EX-stage ALU: single-cycle ops plus a WIDTH-iteration shift-add multiply
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic       clk_i,
  input  logic       rst_i,
  alu_exec_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, MUL} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplr_q, mplr_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             done_q, done_d;
  logic             zero_q, zero_d;

  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] acc_next;
  logic [CW-1:0]    shamt;

  assign shamt = bus.data2_i[CW-1:0];

  always_comb begin
    alu_res = '0;
    case (bus.ctrl_i)
      3'b000: alu_res = bus.data1_i & bus.data2_i;
      3'b001: alu_res = bus.data1_i ^ bus.data2_i;
      3'b010: alu_res = bus.data1_i + bus.data2_i;
      3'b011: alu_res = bus.data1_i << shamt;
      3'b100: alu_res = $signed(bus.data1_i) >>> shamt;
      3'b101: alu_res = bus.data1_i + bus.data2_i;
      3'b110: alu_res = bus.data1_i - bus.data2_i;
      3'b111: alu_res = '0;
      default: alu_res = '0;
    endcase
  end

  assign acc_next = acc_q + (mplr_q[0] ? mcand_q : '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    acc_d   = acc_q;
    data_d  = data_q;
    zero_d  = zero_q;
    done_d  = 1'b0;
    if (bus.abort_i) begin
      // Flush wins over any request presented in the same cycle.
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            if (bus.ctrl_i == 3'b111) begin
              state_d = MUL;
              cnt_d   = '0;
              acc_d   = '0;
              mcand_d = bus.data1_i;
              mplr_d  = bus.data2_i;
            end else begin
              data_d = alu_res;
              zero_d = (alu_res == '0);
              done_d = 1'b1;
            end
          end
        end
        MUL: begin
          acc_d   = acc_next;
          mcand_d = mcand_q << 1;
          mplr_d  = mplr_q >> 1;
          cnt_d   = cnt_q + 1'b1;
          // The last iteration's partial sum goes straight to the result register.
          if (cnt_q == LAST) begin
            data_d  = acc_next;
            zero_d  = (acc_next == '0);
            done_d  = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      done_q  <= done_d;
      zero_q  <= zero_d;
    end
  end

  assign bus.busy_o = (state_q == MUL);
  assign bus.done_o = done_q;
  assign bus.data_o = data_q;
  assign bus.zero_o = zero_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - scoreboard bench for alu_exec_unit with directed and random operations
module tb_alu_exec_unit;
  logic clk;
  logic rst_n;

  alu_exec_if #(.WIDTH(32)) bus ();

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: the result each control code should yield, from plain arithmetic.
  function automatic logic [31:0] model(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    longint unsigned p;
    int sh;
    sh = int'(b % 32);
    case (c)
      3'd0: return a & b;
      3'd1: return a ^ b;
      3'd2, 3'd5: return a + b;
      3'd3: return a << sh;
      3'd4: return (a[31] ? ~((~a) >> sh) : (a >> sh));
      3'd6: return a - b;
      default: begin
        p = longint'(a) * longint'(b);
        return p[31:0];
      end
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus.done_o) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got data 0x%08h expected no result", bus.data_o);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("sb_data", bus.data_o, e);
        check("sb_zero", {31'd0, bus.zero_o}, {31'd0, e == 32'd0});
      end
    end
  end

  task automatic issue(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b, input bit expect_result);
    bus.start_i = 1'b1;
    bus.ctrl_i  = c;
    bus.data1_i = a;
    bus.data2_i = b;
    if (expect_result) exp_q.push_back(model(c, a, b));
    @(negedge clk);
  endtask

  task automatic wait_done(input int bound, input bit noise);
    int n;
    n = 0;
    while (!bus.done_o && n < bound) begin
      if (noise) begin
        bus.start_i = $urandom_range(0, 1);
        bus.ctrl_i  = 3'($urandom_range(0, 7));
        bus.data1_i = $urandom;
        bus.data2_i = $urandom;
      end
      @(negedge clk);
      n++;
    end
    bus.start_i = 1'b0;
    if (!bus.done_o) begin
      checks++;
      errors++;
      $display("FAIL wait_done_timeout: got no done after %0d cycles expected done", bound);
    end
  endtask

  initial begin
    int busy_cycles;
    int done_at;
    int dc;
    bus.start_i = 1'b0;
    bus.ctrl_i  = 3'd0;
    bus.data1_i = 32'd0;
    bus.data2_i = 32'd0;
    bus.abort_i = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", {31'd0, bus.busy_o}, 32'd0);
    check("rst_done", {31'd0, bus.done_o}, 32'd0);
    check("rst_data", bus.data_o, 32'd0);
    check("rst_zero", {31'd0, bus.zero_o}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue(3'd2, 32'hFFFF_FFFF, 32'h1, 1'b1);
    bus.start_i = 1'b0;
    check("add_done_latency", {31'd0, bus.done_o}, 32'd1);
    check("add_wrap_data", bus.data_o, 32'd0);
    @(negedge clk);
    check("add_done_single", {31'd0, bus.done_o}, 32'd0);
    issue(3'd6, 32'd5, 32'd7, 1'b1);
    issue(3'd4, 32'h8000_0000, 32'd4, 1'b1);
    issue(3'd3, 32'h3, 32'h21, 1'b1);
    bus.start_i = 1'b0;
    check("sll_data", bus.data_o, 32'h6);
    @(negedge clk);

    // Multiply with an add request slipped in mid-flight, which must be ignored.
    issue(3'd7, 32'd7, 32'hFFFF_FFFD, 1'b1);
    bus.start_i = 1'b0;
    busy_cycles = 0;
    done_at = 0;
    for (int c = 1; c <= 40; c++) begin
      if (bus.busy_o) busy_cycles++;
      if (bus.done_o) begin
        done_at = c;
        break;
      end
      if (c == 10) begin
        bus.start_i = 1'b1;
        bus.ctrl_i  = 3'd2;
        bus.data1_i = 32'd1;
        bus.data2_i = 32'd1;
      end else begin
        bus.start_i = 1'b0;
      end
      @(negedge clk);
    end
    bus.start_i = 1'b0;
    check("mul_busy_cycles", busy_cycles, 32'd32);
    check("mul_done_cycle", done_at, 32'd33);
    check("mul_busy_in_done", {31'd0, bus.busy_o}, 32'd0);
    check("mul_data", bus.data_o, 32'hFFFF_FFEB);
    @(negedge clk);
    check("mul_done_single", {31'd0, bus.done_o}, 32'd0);

    // Abort an in-flight multiply.
    dc = done_cnt;
    issue(3'd7, 32'd3, 32'd4, 1'b0);
    bus.start_i = 1'b0;
    repeat (3) @(negedge clk);
    bus.abort_i = 1'b1;
    @(negedge clk);
    bus.abort_i = 1'b0;
    check("abort_busy", {31'd0, bus.busy_o}, 32'd0);
    repeat (36) @(negedge clk);
    check("abort_no_done", done_cnt, dc);
    check("abort_data_kept", bus.data_o, 32'hFFFF_FFEB);
    bus.abort_i = 1'b1;
    issue(3'd2, 32'd10, 32'd20, 1'b0);
    bus.abort_i = 1'b0;
    bus.start_i = 1'b0;
    @(negedge clk);
    check("abort_drops_start", done_cnt, dc);
    issue(3'd2, 32'd3, 32'd4, 1'b1);
    bus.start_i = 1'b0;
    check("post_abort_add", bus.data_o, 32'd7);
    @(negedge clk);

    // Asynchronous reset in the middle of a multiply.
    issue(3'd7, 32'h1234_5678, 32'h9ABC_DEF1, 1'b0);
    bus.start_i = 1'b0;
    repeat (18) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, bus.busy_o}, 32'd0);
    check("midrst_done", {31'd0, bus.done_o}, 32'd0);
    check("midrst_data", bus.data_o, 32'd0);
    check("midrst_zero", {31'd0, bus.zero_o}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(3'd7, 32'h0001_0000, 32'h0001_0000, 1'b1);
    bus.start_i = 1'b0;
    wait_done(40, 1'b0);
    check("mul_zero_flag", {31'd0, bus.zero_o}, 32'd1);
    @(negedge clk);

    // Random traffic: back-to-back single-cycle ops and noisy multiplies.
    for (int i = 0; i < 150; i++) begin
      logic [2:0] c;
      logic [31:0] a, b;
      c = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 | $urandom : $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      issue(c, a, b, 1'b1);
      if (c == 3'd7) begin
        bus.start_i = 1'b0;
        wait_done(40, 1'b1);
      end else if ($urandom_range(0, 3) == 0) begin
        bus.start_i = 1'b0;
        @(negedge clk);
      end
    end
    bus.start_i = 1'b0;
    repeat (3) @(negedge clk);
    check("sb_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Sequential execute unit that consumes the 3-bit ALU control code produced by the ALU control decoder. It performs the selected operation on two 32-bit operands. Single-cycle operations complete in one clock. `mul` runs as a 32-iteration shift-add sequence behind a start/busy/done handshake. It sits in the EX stage, and its `busy_o` is used by the hazard unit to stall the pipeline.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width; `mul` iteration count equals `WIDTH`.

Ports:
- `clk_i`  in  1  single clock; all state updates on the rising edge.
- `rst_i`  in  1  reset; asynchronous, active-low.
- `start_i`  in  1  request; sampled only when `busy_o`=0.
- `ctrl_i`  in  3  ALU control code: 000 and, 001 xor, 010 add, 011 sll, 100 srai, 101 addi (add), 110 sub, 111 mul.
- `data1_i`  in  WIDTH  operand 1 (rs1).
- `data2_i`  in  WIDTH  operand 2 (rs2 or immediate).
- `abort_i`  in  1  synchronous flush; cancels an in-flight `mul`.
- `busy_o`  out  1  high while a `mul` iterates.
- `done_o`  out  1  one-cycle pulse; `data_o` is updated in the same cycle.
- `data_o`  out  WIDTH  registered result; holds its value until the next `done_o`.
- `zero_o`  out  1  registered flag, equal to (`data_o`==0).

## Operation
- States: IDLE and MUL.
- Reset (`rst_i`=0, any time, asynchronous) forces:
  - state IDLE, iteration counter 0, internal operand registers 0;
  - `busy_o`=0, `done_o`=0, `data_o`=0, `zero_o`=1.
- IDLE, `start_i`=1, `ctrl_i`≠111: compute combinationally from the inputs and register on the same edge.
  - and/xor: bitwise.
  - add/addi/sub: modulo 2^WIDTH, carry and overflow discarded.
  - sll: `data1_i` << `data2_i[4:0]`.
  - srai: arithmetic right shift of `data1_i` by `data2_i[4:0]`, sign-filled.
  - `done_o`=1 next cycle; state stays IDLE.
- IDLE, `start_i`=1, `ctrl_i`=111: latch operands and enter MUL with counter=0, accumulator=0.
  - Multiplicand register = `data1_i`; multiplier register = `data2_i`.
- MUL, each cycle:
  - if multiplier[0], accumulator += multiplicand (mod 2^WIDTH);
  - multiplicand <<= 1; multiplier >>= 1 (logical); counter += 1.
  - When counter reaches WIDTH-1 on an iteration edge, that edge also writes the final accumulator to `data_o`, pulses `done_o`, and returns to IDLE.
  - Result is the low WIDTH bits of the product, so signed and unsigned operands give identical results.
- `start_i` while `busy_o`=1: ignored entirely; no queueing and no effect on operands.
- `abort_i`=1: returns to IDLE, clears the counter, no `done_o`, `data_o` unchanged.
  - `abort_i` has priority over `start_i` in the same cycle; the request is dropped.
- `zero_o` is written only together with `data_o`.

## Timing
- Non-mul latency: `start_i` sampled at edge N → `data_o`/`done_o` valid in the cycle after edge N.
- mul latency: `start_i` at edge N → iterations on edges N+1…N+32 → `done_o`=1 and `data_o` valid in the cycle after edge N+32 (33 cycles).
- `busy_o`=1 in the cycles after edges N…N+31; it is 0 in the `done_o` cycle.
- A new `start_i` may be presented in the `done_o` cycle; back-to-back non-mul operations sustain one result per cycle.
- `done_o` is never high for two consecutive cycles for the same operation.
- Operands are not required to be stable after the `start_i` edge.

## Test plan
- Reset: drive `rst_i`=0 mid-cycle → `busy_o`=0, `done_o`=0, `data_o`=0x00000000, `zero_o`=1 immediately, without waiting for a clock edge.
- Add wrap: add 0xFFFFFFFF + 0x00000001 → `data_o`=0, `zero_o`=1, `done_o` one cycle later. Then sub 5−7 → 0xFFFFFFFE, `zero_o`=0.
- Shifts:
  - srai 0x80000000 by 4 → 0xF8000000.
  - sll 0x00000003 with `data2_i`=0x21 → 0x00000006 (only bits [4:0] of the shift amount are used).
- mul: 7 × 0xFFFFFFFD → 0xFFFFFFEB.
  - `busy_o` high for 32 cycles; `done_o` in cycle 33.
  - `start_i` (add 1+1) at cycle 10 is ignored; `data_o` does not show 2.
- Abort: start mul 3×4, assert `abort_i` at cycle 5 → IDLE, no `done_o`, `data_o` retains the prior value. An immediate add 3+4 then yields 7.
- Reset during mul at cycle 20 → all outputs return to reset values. A fresh mul 0x10000×0x10000 then gives 0x00000000 with `zero_o`=1.
